dma_mem_responder: RTL and testbench

Word-addressed memory target that services the memory-side requests issued by the team's DMA engine (`mem_addr`, `mem_read`, `mem_write`, `mem_data`, `mem_data_ready`). It holds an internal word array, inserts a programmable number of wait states, and returns a one-cycle `mem_data_ready` completion per accepted request. It is the responder at the far end of the DMA memory interface and serves as both synthesizable scratch RAM and the bench target for DMA verification.

---
 rtl/dma_mem_responder.sv | 153 +++++++++++++++
 tb/tb_dma_mem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_responder.sv
// Word-addressed scratch memory answering DMA engine memory-side requests.
// Latency: completion pulse WAIT_CYCLES+2 edges after the request is first seen.
// Backpressure: none on the data path; requests are simply not accepted while busy.
//
// Ports:
//   clk             single clock, all state updates on its rising edge
//   reset           synchronous, active-high; aborts any transaction in flight
//   mem_addr        word address of the request (offset by BASE_ADDR)
//   mem_read        read request, level-sensitive, sampled only while idle
//   mem_write       write request, level-sensitive, sampled only while idle
//   mem_data        write data, latched together with the address at acceptance
//   mem_data_ready  one-cycle completion pulse
//   mem_rdata       read data, valid with mem_data_ready, held until next completion
//   mem_error       completion carries an error (out of range or read+write together)
//   busy            high whenever a transaction is in progress

module dma_mem_responder #(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_data,
    output logic        mem_data_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;

    // Request captured at acceptance; the live inputs are ignored afterwards.
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        lat_rd;
    logic        lat_wr;

    logic [31:0] mem_array [DEPTH];

    logic        accept;
    logic        access;
    logic [31:0] idx_full;
    logic [AW-1:0] idx;
    logic        in_range;
    logic        op_illegal;
    logic        access_ok;
    logic        commit_write;
    logic [31:0] rdata_nxt;

    // Addresses below BASE_ADDR wrap to huge indices and fall out of range
    // through the same unsigned compare.
    assign idx_full   = lat_addr - BASE_ADDR;
    assign idx        = idx_full[AW-1:0];
    assign in_range   = (idx_full < 32'(DEPTH));
    assign op_illegal = lat_rd && lat_wr;
    assign access_ok  = in_range && !op_illegal;

    // A write commits only on the WAIT->DONE edge, and never on a reset edge,
    // so a reset anywhere before completion drops the write entirely.
    assign commit_write = access && !reset && access_ok && lat_wr;

    // Only a legal in-range read returns array contents; everything else
    // completes with zero data.
    assign rdata_nxt = (access_ok && lat_rd) ? mem_array[idx] : 32'h0;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        access    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= 4'd0;
            lat_addr       <= 32'h0;
            lat_data       <= 32'h0;
            lat_rd         <= 1'b0;
            lat_wr         <= 1'b0;
            mem_data_ready <= 1'b0;
            mem_rdata      <= 32'h0;
            mem_error      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                lat_addr <= mem_addr;
                lat_data <= mem_data;
                lat_rd   <= mem_read;
                lat_wr   <= mem_write;
                wait_cnt <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // Ready is high exactly for the DONE cycle.
            mem_data_ready <= access;

            if (access) begin
                mem_rdata <= rdata_nxt;
                mem_error <= !access_ok;
            end else if (state == DONE) begin
                // Error is only meaningful alongside ready; rdata is held.
                mem_error <= 1'b0;
            end
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (commit_write) begin
            mem_array[idx] <= lat_data;
        end
    end

endmodule

// File: tb/tb_dma_mem_responder.sv
module tb_dma_mem_responder;

    logic        clk = 1'b0;
    logic        reset_s [3];
    logic [31:0] addr_s  [3];
    logic        rd_s    [3];
    logic        wr_s    [3];
    logic [31:0] data_s  [3];
    logic        rdy_s   [3];
    logic [31:0] rdata_s [3];
    logic        err_s   [3];
    logic        busy_s  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults (BASE 0, 2 wait states)
    dma_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .reset(reset_s[0]), .mem_addr(addr_s[0]), .mem_read(rd_s[0]),
        .mem_write(wr_s[0]), .mem_data(data_s[0]), .mem_data_ready(rdy_s[0]),
        .mem_rdata(rdata_s[0]), .mem_error(err_s[0]), .busy(busy_s[0]));

    // Instance 1: zero wait states
    dma_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_z (
        .clk(clk), .reset(reset_s[1]), .mem_addr(addr_s[1]), .mem_read(rd_s[1]),
        .mem_write(wr_s[1]), .mem_data(data_s[1]), .mem_data_ready(rdy_s[1]),
        .mem_rdata(rdata_s[1]), .mem_error(err_s[1]), .busy(busy_s[1]));

    // Instance 2: BASE 0x100, 2 wait states
    dma_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h100), .WAIT_CYCLES(2)) u_b (
        .clk(clk), .reset(reset_s[2]), .mem_addr(addr_s[2]), .mem_read(rd_s[2]),
        .mem_write(wr_s[2]), .mem_data(data_s[2]), .mem_data_ready(rdy_s[2]),
        .mem_rdata(rdata_s[2]), .mem_error(err_s[2]), .busy(busy_s[2]));

    // Issues one request starting at a negedge, holds it until ready is seen
    // (bounded), drops it in the DONE cycle, then samples one cycle later.
    // lat = number of rising edges from first visibility to ready, -1 on timeout.
    task automatic req(input int s, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rdat, output logic err,
                       output logic rdy_after, output logic busy_after);
        rd_s[s] = rd; wr_s[s] = wr; addr_s[s] = a; data_s[s] = d;
        lat = -1; rdat = 32'h0; err = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); @(negedge clk);
            if (rdy_s[s]) begin
                lat = e; rdat = rdata_s[s]; err = err_s[s];
                break;
            end
        end
        rd_s[s] = 1'b0; wr_s[s] = 1'b0;
        @(posedge clk); @(negedge clk);
        rdy_after  = rdy_s[s];
        busy_after = busy_s[s];
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            reset_s[s] = 1'b1; rd_s[s] = 1'b0; wr_s[s] = 1'b0;
            addr_s[s] = 32'h0; data_s[s] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            total++;
            if ({rdy_s[s], err_s[s], busy_s[s]} !== 3'b000 || rdata_s[s] !== 32'h0) begin
                bad++;
                $display("FAIL reset_state inst=%0d got rdy=%b err=%b busy=%b rdata=%h want 0/0/0/0",
                         s, rdy_s[s], err_s[s], busy_s[s], rdata_s[s]);
            end
            reset_s[s] = 1'b0;
        end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic er, ra, ba;
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, ra, ba);
        total++;
        if (lat !== 4 || er !== 1'b0 || ra !== 1'b0) begin
            bad++;
            $display("FAIL wr_basic got lat=%0d err=%b rdy_after=%b want 4/0/0", lat, er, ra);
        end
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd, er, ra, ba);
        total++;
        if (lat !== 4 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            bad++;
            $display("FAIL rd_basic got lat=%0d rdata=%h err=%b want 4/deadbeef/0", lat, rd, er);
        end
        total++;
        if (ra !== 1'b0 || ba !== 1'b0) begin
            bad++;
            $display("FAIL rd_single_cycle got rdy_after=%b busy_after=%b want 0/0", ra, ba);
        end
        total++;
        if (rdata_s[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rdata_hold got %h want deadbeef", rdata_s[0]);
        end
    endtask

    task automatic test_zero_wait();
        int lat; logic [31:0] rd; logic er, ra, ba;
        req(1, 1'b0, 1'b1, 32'h1, 32'h5, lat, rd, er, ra, ba);
        total++;
        if (lat !== 2 || er !== 1'b0 || ra !== 1'b0 || ba !== 1'b0) begin
            bad++;
            $display("FAIL zw_write got lat=%0d err=%b rdy_after=%b busy_after=%b want 2/0/0/0",
                     lat, er, ra, ba);
        end
        // Issued immediately: acceptance exactly 3 edges after the previous one.
        req(1, 1'b1, 1'b0, 32'h1, 32'h0, lat, rd, er, ra, ba);
        total++;
        if (lat !== 2 || rd !== 32'h5 || er !== 1'b0) begin
            bad++;
            $display("FAIL zw_read got lat=%0d rdata=%h err=%b want 2/5/0", lat, rd, er);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er, ra, ba;
        req(2, 1'b0, 1'b1, 32'h100, 32'hCAFE0001, lat, rd, er, ra, ba);
        req(2, 1'b0, 1'b1, 32'h1FF, 32'hBEEF01FF, lat, rd, er, ra, ba);
        total++;
        if (er !== 1'b0 || lat !== 4) begin
            bad++;
            $display("FAIL oor_top_write got err=%b lat=%0d want 0/4", er, lat);
        end
        req(2, 1'b1, 1'b0, 32'h100, 32'h0, lat, rd, er, ra, ba);
        req(2, 1'b1, 1'b0, 32'h0FF, 32'h0, lat, rd, er, ra, ba);
        total++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 4) begin
            bad++;
            $display("FAIL oor_below got err=%b rdata=%h lat=%0d want 1/0/4", er, rd, lat);
        end
        req(2, 1'b0, 1'b1, 32'h200, 32'h00000077, lat, rd, er, ra, ba);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL oor_above got err=%b rdata=%h want 1/0", er, rd);
        end
        req(2, 1'b1, 1'b0, 32'h100, 32'h0, lat, rd, er, ra, ba);
        total++;
        if (er !== 1'b0 || rd !== 32'hCAFE0001) begin
            bad++;
            $display("FAIL oor_no_change got err=%b rdata=%h want 0/cafe0001", er, rd);
        end
        req(2, 1'b1, 1'b0, 32'h1FF, 32'h0, lat, rd, er, ra, ba);
        total++;
        if (er !== 1'b0 || rd !== 32'hBEEF01FF) begin
            bad++;
            $display("FAIL oor_top_read got err=%b rdata=%h want 0/beef01ff", er, rd);
        end
    endtask

    task automatic test_illegal_op();
        int lat; logic [31:0] rd; logic er, ra, ba;
        req(2, 1'b0, 1'b1, 32'h120, 32'h0000ABCD, lat, rd, er, ra, ba);
        req(2, 1'b1, 1'b0, 32'h120, 32'h0, lat, rd, er, ra, ba);
        req(2, 1'b1, 1'b1, 32'h120, 32'h00001234, lat, rd, er, ra, ba);
        total++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 4) begin
            bad++;
            $display("FAIL illegal_op got err=%b rdata=%h lat=%0d want 1/0/4", er, rd, lat);
        end
        req(2, 1'b1, 1'b0, 32'h120, 32'h0, lat, rd, er, ra, ba);
        total++;
        if (er !== 1'b0 || rd !== 32'h0000ABCD) begin
            bad++;
            $display("FAIL illegal_no_change got err=%b rdata=%h want 0/0000abcd", er, rd);
        end
    endtask

    // Reset after k edges of a write: k=1 is mid-WAIT, k=3 lands on the commit edge.
    task automatic test_reset_mid_wait();
        int lat; logic [31:0] rd; logic er, ra, ba;
        int k; int pulses;
        req(2, 1'b0, 1'b1, 32'h130, 32'h00005555, lat, rd, er, ra, ba);
        for (int pass = 0; pass < 2; pass++) begin
            k = (pass == 0) ? 1 : 3;
            req(2, 1'b1, 1'b0, 32'h130, 32'h0, lat, rd, er, ra, ba);
            wr_s[2] = 1'b1; addr_s[2] = 32'h130; data_s[2] = 32'h0000AAAA;
            repeat (k) begin @(posedge clk); @(negedge clk); end
            total++;
            if (busy_s[2] !== 1'b1) begin
                bad++;
                $display("FAIL rst_busy_before k=%0d got %b want 1", k, busy_s[2]);
            end
            wr_s[2] = 1'b0; reset_s[2] = 1'b1;
            @(posedge clk); @(negedge clk);
            reset_s[2] = 1'b0;
            total++;
            if (busy_s[2] !== 1'b0 || rdy_s[2] !== 1'b0 || err_s[2] !== 1'b0 || rdata_s[2] !== 32'h0) begin
                bad++;
                $display("FAIL rst_abort k=%0d got busy=%b rdy=%b err=%b rdata=%h want 0/0/0/0",
                         k, busy_s[2], rdy_s[2], err_s[2], rdata_s[2]);
            end
            pulses = 0;
            repeat (8) begin
                @(posedge clk); @(negedge clk);
                if (rdy_s[2]) pulses++;
            end
            total++;
            if (pulses !== 0) begin
                bad++;
                $display("FAIL rst_no_pulse k=%0d got %0d pulses want 0", k, pulses);
            end
            req(2, 1'b1, 1'b0, 32'h130, 32'h0, lat, rd, er, ra, ba);
            total++;
            if (rd !== 32'h00005555 || er !== 1'b0) begin
                bad++;
                $display("FAIL rst_write_dropped k=%0d got rdata=%h err=%b want 00005555/0", k, rd, er);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er, ra, ba;
        logic [9:0] seen;
        logic [31:0] d_first, d_second;
        req(2, 1'b0, 1'b1, 32'h140, 32'h11110140, lat, rd, er, ra, ba);
        req(2, 1'b0, 1'b1, 32'h150, 32'h22220150, lat, rd, er, ra, ba);
        seen = 10'h0; d_first = 32'h0; d_second = 32'h0;
        rd_s[2] = 1'b1; addr_s[2] = 32'h140;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); @(negedge clk);
            seen[e-1] = rdy_s[2];
            if (e == 1) addr_s[2] = 32'h150;
            if (e == 4) d_first = rdata_s[2];
            if (e == 9) begin
                d_second = rdata_s[2];
                rd_s[2] = 1'b0;
            end
        end
        total++;
        if (seen !== 10'b01_0000_1000) begin
            bad++;
            $display("FAIL held_ready_edges got %b want 0100001000", seen);
        end
        total++;
        if (d_first !== 32'h11110140 || d_second !== 32'h22220150) begin
            bad++;
            $display("FAIL held_data got %h,%h want 11110140,22220150", d_first, d_second);
        end
        total++;
        if (busy_s[2] !== 1'b0) begin
            bad++;
            $display("FAIL held_idle got busy=%b want 0", busy_s[2]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_out_of_range();
        test_illegal_op();
        test_reset_mid_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
